// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin arbitration of two requesters plus a full-frame
// clear engine. Define FB_BOUNDS_CHECK_EN to drop and flag writes with addr >= Pixels.
module fb_write_arbiter #(
  parameter int unsigned Pixels = 921600,
  parameter int unsigned AddrW  = $clog2(Pixels),
  parameter int unsigned DataW  = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             r0_valid_i,
  input  logic [AddrW-1:0] r0_addr_i,
  input  logic [DataW-1:0] r0_data_i,
  output logic             r0_ready_o,
  input  logic             r1_valid_i,
  input  logic [AddrW-1:0] r1_addr_i,
  input  logic [DataW-1:0] r1_data_i,
  output logic             r1_ready_o,
  input  logic             clr_start_i,
  input  logic [DataW-1:0] clr_color_i,
  output logic             clr_busy_o,
  output logic             clr_done_o,
  input  logic             err_clr_i,
  output logic             oob_err_o,
  output logic             vram_we_o,
  output logic [AddrW-1:0] vram_addr_o,
  output logic [DataW-1:0] vram_data_o
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Pixels - 1);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [DataW-1:0] color_q, color_d;
  logic             last_q, last_d;  // index of the requester served last
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             gnt0, gnt1;
  logic [AddrW-1:0] gnt_addr;
  logic [DataW-1:0] gnt_data;
  logic             oob_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      color_q <= '0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clr_start_i) state_d = StClear;
      StClear: if (cnt_q == LastAddr) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grants are only possible in IDLE; on contention the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !rst_i) begin
      if (r0_valid_i && r1_valid_i) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = r0_valid_i;
        gnt1 = r1_valid_i;
      end
    end
  end

  always_comb begin
    r0_ready_o  = gnt0;
    r1_ready_o  = gnt1;
    clr_busy_o  = (state_q != StIdle);
    clr_done_o  = (state_q == StDone);
    vram_we_o   = we_q;
    vram_addr_o = addr_q;
    vram_data_o = data_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    color_d = color_q;
    last_d  = last_q;
    if (state_q == StIdle && clr_start_i) begin
      cnt_d   = '0;
      color_d = clr_color_i;
    end else if (state_q == StClear && cnt_q != LastAddr) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
  end

  assign gnt_addr = gnt1 ? r1_addr_i : r0_addr_i;
  assign gnt_data = gnt1 ? r1_data_i : r0_data_i;

`ifdef FB_BOUNDS_CHECK_EN
  localparam logic [AddrW:0] PixLimit = (AddrW + 1)'(Pixels);

  logic oob_q, oob_d;

  assign oob_hit = (gnt0 || gnt1) && ({1'b0, gnt_addr} >= PixLimit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) oob_q <= 1'b0;
    else       oob_q <= oob_d;
  end

  // A new violation takes priority over a simultaneous clear request.
  always_comb begin
    oob_d = oob_q;
    if (err_clr_i) oob_d = 1'b0;
    if (oob_hit)   oob_d = 1'b1;
  end

  assign oob_err_o = oob_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign oob_hit        = 1'b0;
  assign oob_err_o      = 1'b0;
`endif

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == StClear) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      data_d = color_q;
    end else if ((gnt0 || gnt1) && !oob_hit) begin
      we_d   = 1'b1;
      addr_d = gnt_addr;
      data_d = gnt_data;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: a timeline model of grants and clear windows checked every
// cycle, directed literal checks, and a small Pixels=12 instance for the bounds-check path.
module tb_fb_write_arbiter;

  localparam int Pix = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0, clr_start = 1'b0, err_clr = 1'b0;
  logic [3:0]  r0_addr = '0, r1_addr = '0;
  logic [23:0] r0_data = '0, r1_data = '0, clr_color = '0;
  logic        r0_ready, r1_ready, clr_busy, clr_done, oob_err, vram_we;
  logic [3:0]  vram_addr;
  logic [23:0] vram_data;

  logic        o_r0_valid = 1'b0, o_err_clr = 1'b0;
  logic [3:0]  o_r0_addr = '0;
  logic [23:0] o_r0_data = '0;
  logic        o_r0_ready, o_r1_ready, o_busy, o_done, o_oob, o_we;
  logic [3:0]  o_addr;
  logic [23:0] o_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_write_arbiter #(.Pixels(Pix), .AddrW(4), .DataW(24)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .r0_valid_i(r0_valid), .r0_addr_i(r0_addr), .r0_data_i(r0_data), .r0_ready_o(r0_ready),
    .r1_valid_i(r1_valid), .r1_addr_i(r1_addr), .r1_data_i(r1_data), .r1_ready_o(r1_ready),
    .clr_start_i(clr_start), .clr_color_i(clr_color), .clr_busy_o(clr_busy),
    .clr_done_o(clr_done), .err_clr_i(err_clr), .oob_err_o(oob_err),
    .vram_we_o(vram_we), .vram_addr_o(vram_addr), .vram_data_o(vram_data)
  );

  fb_write_arbiter #(.Pixels(12), .AddrW(4), .DataW(24)) u_oob (
    .clk_i(clk), .rst_i(rst),
    .r0_valid_i(o_r0_valid), .r0_addr_i(o_r0_addr), .r0_data_i(o_r0_data),
    .r0_ready_o(o_r0_ready),
    .r1_valid_i(1'b0), .r1_addr_i(4'd0), .r1_data_i(24'd0), .r1_ready_o(o_r1_ready),
    .clr_start_i(1'b0), .clr_color_i(24'd0), .clr_busy_o(o_busy), .clr_done_o(o_done),
    .err_clr_i(o_err_clr), .oob_err_o(o_oob),
    .vram_we_o(o_we), .vram_addr_o(o_addr), .vram_data_o(o_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a clear started in cycle cs occupies cycles cs+1..cs+1+Pix; writes are issued in
  // cycles cs+1..cs+Pix for addresses 0..Pix-1 and appear one cycle after issue.
  int          cs = -100;
  int          busy_end = -1;
  bit          m_last = 1'b1;
  bit          pend_we = 1'b0;
  logic [3:0]  pend_addr = '0, cur_addr = '0;
  logic [23:0] pend_data = '0, cur_data = '0, clr_col = '0;
  logic [23:0] shadow [Pix];

  always @(negedge clk) begin
    bit idle, e0, e1;
    if (rst) begin
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_busy", clr_busy, 0);
      chk("rst_done", clr_done, 0);
      chk("rst_we", vram_we, 0);
      chk("rst_addr", vram_addr, 0);
      chk("rst_data", vram_data, 0);
      chk("rst_oob", oob_err, 0);
      cs = -100; busy_end = -1; m_last = 1'b1; pend_we = 1'b0;
      cur_addr = '0; cur_data = '0;
    end else begin
      if (vram_we) shadow[vram_addr] = vram_data;
      if (pend_we) begin
        cur_addr = pend_addr;
        cur_data = pend_data;
      end
      idle = (cyc > busy_end);
      e0 = idle && r0_valid && (!r1_valid || m_last);
      e1 = idle && r1_valid && (!r0_valid || !m_last);
      chk("m_r0_ready", r0_ready, e0);
      chk("m_r1_ready", r1_ready, e1);
      chk("m_busy", clr_busy, !idle);
      chk("m_done", clr_done, cyc == busy_end);
      chk("m_we", vram_we, pend_we);
      chk("m_addr", vram_addr, cur_addr);
      chk("m_data", vram_data, cur_data);
      chk("m_oob", oob_err, 0);
      pend_we = 1'b0;
      if (!idle && cyc <= cs + Pix) begin
        pend_we = 1'b1; pend_addr = 4'(cyc - cs - 1); pend_data = clr_col;
      end else if (e0) begin
        pend_we = 1'b1; pend_addr = r0_addr; pend_data = r0_data; m_last = 1'b0;
      end else if (e1) begin
        pend_we = 1'b1; pend_addr = r1_addr; pend_data = r1_data; m_last = 1'b1;
      end
      if (idle && clr_start) begin
        cs = cyc; busy_end = cyc + 1 + Pix; clr_col = clr_color;
      end
    end
  end

  initial begin
    bit [3:0] order;
    repeat (2) tick();
    rst = 1'b0;

    // Test 1: reset in the middle of a clear, then immediate grant after release.
    tick(); clr_start = 1'b1; clr_color = 24'h445566;
    tick(); clr_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t1_we_now", vram_we, 0);
    chk("t1_busy_now", clr_busy, 0);
    chk("t1_data_now", vram_data, 0);
    tick();
    tick(); rst = 1'b0; r0_valid = 1'b1; r0_addr = 4'd5; r0_data = 24'h00B4FF;
    #1;
    chk("t1_r0_ready", r0_ready, 1);

    // Test 2: single write, one-cycle latency.
    tick(); r0_valid = 1'b0;
    @(negedge clk);
    chk("t2_we", vram_we, 1);
    chk("t2_addr", vram_addr, 4'd5);
    chk("t2_data", vram_data, 24'h00B4FF);
    tick();
    @(negedge clk);
    chk("t2_we_off", vram_we, 0);

    // Test 3: contention from a fresh pointer alternates r0, r1, r0, r1.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    r0_valid = 1'b1; r0_addr = 4'd1; r0_data = 24'h0000AA;
    r1_valid = 1'b1; r1_addr = 4'd2; r1_data = 24'h0000BB;
    order = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_gnt0", r0_ready, order[i]);
      chk("t3_gnt1", r1_ready, !order[i]);
      if (i > 0) chk("t3_we", vram_we, 1);
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    chk("t3_we_last", vram_we, 1);
    chk("t3_data_last", vram_data, 24'h0000BB);

    // Test 4: full clear, ignored second start, r0 stalled until the clear retires.
    tick(); clr_start = 1'b1; clr_color = 24'h112233;
    for (int k = 1; k <= 18; k++) begin
      tick();
      clr_start = (k == 5);
      clr_color = (k == 5) ? 24'hFFFFFF : 24'h112233;
      r0_valid = 1'b1; r0_addr = 4'd7; r0_data = 24'h777777;
      @(negedge clk);
      chk("t4_r0_ready", r0_ready, k == 18);
      chk("t4_done", clr_done, k == 17);
      if (k >= 2 && k <= 17) begin
        chk("t4_addr", vram_addr, 32'(k - 2));
        chk("t4_data", vram_data, 24'h112233);
      end
    end
    tick(); r0_valid = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    chk("t4_r0_write", vram_data, 24'h777777);
    tick();
    chk("t4_mem0", shadow[0], 24'h112233);
    chk("t4_mem15", shadow[15], 24'h112233);
    chk("t4_mem7", shadow[7], 24'h777777);

    // Test 5: request granted in the clr_start cycle lands first, then gets overwritten.
    clr_start = 1'b1; clr_color = 24'h112233;
    r1_valid = 1'b1; r1_addr = 4'd3; r1_data = 24'hAAAAAA;
    @(negedge clk);
    chk("t5_r1_ready", r1_ready, 1);
    tick(); clr_start = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    chk("t5_r1_addr", vram_addr, 4'd3);
    chk("t5_r1_data", vram_data, 24'hAAAAAA);
    repeat (18) tick();
    chk("t5_mem3", shadow[3], 24'h112233);

    // Test 6: out-of-range address on a Pixels=12 instance.
    o_r0_valid = 1'b1; o_r0_addr = 4'd13; o_r0_data = 24'h123456;
    @(negedge clk);
    chk("t6_ready", o_r0_ready, 1);
    tick(); o_r0_valid = 1'b0;
    @(negedge clk);
`ifdef FB_BOUNDS_CHECK_EN
    chk("t6_we", o_we, 0);
    chk("t6_oob", o_oob, 1);
    tick(); o_err_clr = 1'b1;
    o_r0_valid = 1'b1; o_r0_addr = 4'd12;
    tick(); o_err_clr = 1'b0; o_r0_valid = 1'b0;
    @(negedge clk);
    chk("t6_set_wins", o_oob, 1);
    tick(); o_err_clr = 1'b1;
    tick(); o_err_clr = 1'b0;
    @(negedge clk);
    chk("t6_cleared", o_oob, 0);
`else
    chk("t6_we", o_we, 1);
    chk("t6_addr", o_addr, 4'd13);
    chk("t6_oob", o_oob, 0);
`endif
    tick(); o_r0_valid = 1'b1; o_r0_addr = 4'd4; o_r0_data = 24'h0A0B0C;
    tick(); o_r0_valid = 1'b0;
    @(negedge clk);
    chk("t6_inrange_we", o_we, 1);
    chk("t6_inrange_data", o_data, 24'h0A0B0C);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
